shift_reg_univ: RTL

- Parametrised universal shift register; successor to the fixed 4-bit serial-in shift register.
- Adds configurable width, per-cycle mode select (hold, shift left/right, rotate left/right, parallel load) and a clock enable.
- Adds a shift counter that pulses when a full word has been shifted, plus a sticky illegal-mode flag.
- Used as the serial/parallel conversion primitive in later designs.

---
 rtl/shift_reg_univ_pkg.sv | 35 +++
 rtl/shreg_word_counter.sv | 55 +++++
 rtl/shift_reg_univ.sv | 89 ++++++++
 3 files changed

// File: rtl/shift_reg_univ_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_univ_pkg
// Description : Shared types and helpers for the universal shift register.
//               Defines the mode encoding and the shift-class classifier used
//               by both the data path and the word counter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_univ_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_RSV6 = 3'b110,
        MODE_RSV7 = 3'b111
    } shreg_mode_e;

    // Shift class: every mode that moves the word by one bit position,
    // regardless of direction or of whether the vacated bit is serial or
    // rotated. These are the operations that advance the word counter.
    function automatic logic is_shift(input shreg_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

    function automatic logic is_reserved(input shreg_mode_e m);
        return (m == MODE_RSV6) || (m == MODE_RSV7);
    endfunction

endpackage : shift_reg_univ_pkg
`default_nettype wire

// File: rtl/shreg_word_counter.sv
`default_nettype none
// ============================================================================
// Module      : shreg_word_counter
// Description : Counts single-bit shift operations within a word and emits a
//               registered one-cycle pulse when WIDTH shifts have completed.
//               A parallel load restarts the word.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-low reset
//               en         - clock enable (0 holds cnt, drops word_done)
//               is_shift   - current op is SHL/SHR/ROTL/ROTR
//               is_load    - current op is LOAD
//               cnt        - shifts completed in the current word
//               word_done  - one-cycle pulse after the WIDTH-th shift
// Revision    : 1.0 - initial release
// ============================================================================
module shreg_word_counter #(
    parameter int WIDTH = 4,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          is_shift,
    input  logic          is_load,
    output logic [CW-1:0] cnt,
    output logic          word_done
);

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            // Pulse lasts exactly one cycle; it is only re-raised by another
            // wrapping shift, so a disabled cycle never stretches it.
            word_done <= 1'b0;
            if (en) begin
                if (is_load) begin
                    cnt <= '0;
                end else if (is_shift) begin
                    if (cnt == C_LAST) begin
                        cnt       <= '0;
                        word_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule : shreg_word_counter
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_univ
// Description : Parametrised universal shift register with hold, shift
//               left/right, rotate left/right and parallel load, a clock
//               enable, a word-complete counter and a sticky illegal-mode flag.
// Ports       : clk, rst (async active-low), en, mode[2:0], si, pi[WIDTH],
//               o[WIDTH], so_msb, so_lsb, cnt[CW], word_done, err
//               With SHIFT_REG_UNIV_PARITY_EN defined: parity (out), par_odd (in)
// Options     : SHIFT_REG_UNIV_PARITY_EN - adds the combinational parity output
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] o,
    output logic             so_msb,
    output logic             so_lsb,
    output logic [CW-1:0]    cnt,
    output logic             word_done,
    output logic             err
`ifdef SHIFT_REG_UNIV_PARITY_EN
    ,
    output logic             parity,
    input  logic             par_odd
`endif
);

    shreg_mode_e      w_mode;
    logic [WIDTH-1:0] w_next;

    assign w_mode = shreg_mode_e'(mode);

    // Next-state data; reserved encodings fall through to hold.
    always_comb begin
        w_next = o;
        case (w_mode)
            MODE_SHL:  w_next = {o[WIDTH-2:0], si};
            MODE_SHR:  w_next = {si, o[WIDTH-1:1]};
            MODE_LOAD: w_next = pi;
            MODE_ROTL: w_next = {o[WIDTH-2:0], o[WIDTH-1]};
            MODE_ROTR: w_next = {o[0], o[WIDTH-1:1]};
            default:   w_next = o;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o   <= RST_VAL;
            err <= 1'b0;
        end else if (en) begin
            o <= w_next;
            if (is_reserved(w_mode)) begin
                err <= 1'b1;
            end
        end
    end

    assign so_msb = o[WIDTH-1];
    assign so_lsb = o[0];

    shreg_word_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .is_shift  (is_shift(w_mode)),
        .is_load   (w_mode == MODE_LOAD),
        .cnt       (cnt),
        .word_done (word_done)
    );

`ifdef SHIFT_REG_UNIV_PARITY_EN
    assign parity = (^o) ^ par_odd;
`endif

endmodule : shift_reg_univ
`default_nettype wire
